// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// opcode numbers, ALU select codes and the instruction-class one-hot layout.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    OPERAND = 3'd1,
    MEM     = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_e;

  localparam int OP_NOP     = 0;
  localparam int OP_MOV_R2C = 1;
  localparam int OP_MOV_K2C = 2;
  localparam int OP_MOV_C2R = 3;
  localparam int OP_MOV_R2A = 4;
  localparam int OP_LOAD    = 5;
  localparam int OP_STORE   = 6;
  localparam int OP_NOT     = 7;
  localparam int OP_AND     = 8;
  localparam int OP_OR      = 9;
  localparam int OP_XOR     = 10;
  localparam int OP_ADD     = 11;
  localparam int OP_SUB     = 12;
  localparam int OP_INC     = 13;
  localparam int OP_JMP     = 14;
  localparam int OP_HALT    = 15;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_NOT  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_ADD  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  // Bit positions in the one-hot instruction class vector.
  localparam int CLS_W       = 11;
  localparam int CLS_NOP     = 0;
  localparam int CLS_MOV_R2C = 1;
  localparam int CLS_MOV_K2C = 2;
  localparam int CLS_MOV_C2R = 3;
  localparam int CLS_MOV_R2A = 4;
  localparam int CLS_LOAD    = 5;
  localparam int CLS_STORE   = 6;
  localparam int CLS_ALU     = 7;
  localparam int CLS_JMP     = 8;
  localparam int CLS_HALT    = 9;
  localparam int CLS_ILLEGAL = 10;

  function automatic logic is_two_word(input int opc);
    return (opc == OP_MOV_K2C) || (opc == OP_LOAD) ||
           (opc == OP_STORE)   || (opc == OP_JMP);
  endfunction

endpackage

// File: rtl/cu_opcode_decoder.sv
// Combinational opcode decode: one-hot instruction class plus ALU function.
module cu_opcode_decoder import cu_pkg::*; #(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [CLS_W-1:0] cls,
  output logic [2:0]       alu_sel
);

  always_comb begin
    cls     = '0;
    alu_sel = ALU_NONE;
    case (int'(opcode))
      OP_NOP:     cls[CLS_NOP]     = 1'b1;
      OP_MOV_R2C: cls[CLS_MOV_R2C] = 1'b1;
      OP_MOV_K2C: cls[CLS_MOV_K2C] = 1'b1;
      OP_MOV_C2R: cls[CLS_MOV_C2R] = 1'b1;
      OP_MOV_R2A: cls[CLS_MOV_R2A] = 1'b1;
      OP_LOAD:    cls[CLS_LOAD]    = 1'b1;
      OP_STORE:   cls[CLS_STORE]   = 1'b1;
      OP_NOT:     begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_NOT; end
      OP_AND:     begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_AND; end
      OP_OR:      begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_OR;  end
      OP_XOR:     begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_XOR; end
      OP_ADD:     begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_ADD; end
      OP_SUB:     begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_SUB; end
      OP_INC:     begin cls[CLS_ALU] = 1'b1; alu_sel = ALU_INC; end
      OP_JMP:     cls[CLS_JMP]     = 1'b1;
      OP_HALT:    cls[CLS_HALT]    = 1'b1;
      default:    cls[CLS_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: owns PC/IR, fetches over req/ack and sequences the datapath.
// Optional: define TRAP_ILLEGAL_EN to halt on illegal opcodes and expose illegal_op.
module multicycle_control_unit import cu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 5,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [REG_W-1:0]  reg_sel,
  output logic [2:0]        alu_sel,
  output logic              r_in,
  output logic              r_out,
  output logic              ra_in,
  output logic              rc_in,
  output logic              rc_out,
  output logic              gen_const,
  output logic              mem_to_rc,
  output logic [DATA_W-1:0] const_val,
  output logic              halted,
`ifdef TRAP_ILLEGAL_EN
  output logic              illegal_op,
`endif
  output logic [2:0]        state_dbg
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic              req_en_q, req_en_d;
  logic [CLS_W-1:0]  cls;
  logic [2:0]        alu_dec;
  int                fetch_opc;
  logic              unused_cls;

  cu_opcode_decoder #(.OPC_W(OPC_W)) u_dec (
    .opcode  (ir_q[DATA_W-1 -: OPC_W]),
    .cls     (cls),
    .alu_sel (alu_dec)
  );

  assign fetch_opc  = int'(mem_rdata[DATA_W-1 -: OPC_W]);
  assign unused_cls = ^{cls[CLS_NOP], cls[CLS_ILLEGAL]};
  assign const_val  = opnd_q;
  assign state_dbg  = state_q;

`ifdef TRAP_ILLEGAL_EN
  logic illegal_q, illegal_d;
  assign illegal_op = illegal_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      opnd_q   <= '0;
      req_en_q <= 1'b0;
`ifdef TRAP_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      req_en_q <= req_en_d;
`ifdef TRAP_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // req_en_q keeps the very first cycle after reset release request-free.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    req_en_d  = 1'b1;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    reg_sel   = '0;
    alu_sel   = ALU_NONE;
    r_in      = 1'b0;
    r_out     = 1'b0;
    ra_in     = 1'b0;
    rc_in     = 1'b0;
    rc_out    = 1'b0;
    gen_const = 1'b0;
    mem_to_rc = 1'b0;
    halted    = 1'b0;
`ifdef TRAP_ILLEGAL_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      FETCH: begin
        if (req_en_q) begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
          if (mem_ack) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + PC_ONE;
            state_d = is_two_word(fetch_opc) ? OPERAND : EXEC;
`ifdef TRAP_ILLEGAL_EN
            if (fetch_opc > OP_HALT) begin
              state_d   = HALT;
              illegal_d = 1'b1;
            end
`endif
          end
        end
      end
      OPERAND: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          opnd_d  = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = (cls[CLS_LOAD] || cls[CLS_STORE]) ? MEM : EXEC;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_addr = opnd_q[ADDR_W-1:0];
        if (cls[CLS_STORE]) begin
          mem_we = 1'b1;
          rc_out = 1'b1;
        end else if (mem_ack) begin
          mem_to_rc = 1'b1;
          rc_in     = 1'b1;
        end
        if (mem_ack) state_d = FETCH;
      end
      EXEC: begin
        reg_sel = ir_q[REG_W-1:0];
        state_d = FETCH;
        if (cls[CLS_MOV_R2C]) begin r_out = 1'b1; rc_in = 1'b1; end
        if (cls[CLS_MOV_K2C]) begin gen_const = 1'b1; rc_in = 1'b1; end
        if (cls[CLS_MOV_C2R]) begin rc_out = 1'b1; r_in = 1'b1; end
        if (cls[CLS_MOV_R2A]) begin r_out = 1'b1; ra_in = 1'b1; end
        if (cls[CLS_ALU]) begin
          r_out   = 1'b1;
          rc_in   = 1'b1;
          alu_sel = alu_dec;
        end
        if (cls[CLS_JMP]) pc_d = opnd_q[ADDR_W-1:0];
        if (cls[CLS_HALT]) state_d = HALT;
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase
  end

endmodule
